section_input: RTL and testbench

Serial receive stage of the USRT link. It sits directly downstream of `section_output` and consumes its `rts`/`txd` pair as `cts`/`rxd`. It samples one bit per `usrt_pedge` strobe while `cts` is high and assembles 8- or 16-bit words. Each completed word goes to a one-word holding register with a valid/ready handshake, and the stage flags both framing errors and overruns.

---
 rtl/section_input.sv | 138 +++++++++++++
 tb/tb_section_input.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/section_input.sv
// ---------------------------------------------------------------------------
// section_input
//   Serial receive stage of the USRT link. Samples one bit of rxd per
//   usrt_pedge strobe while cts is high, assembles LSB-first 8- or 16-bit
//   words, and hands each completed word to a one-word holding register with
//   a valid/ready handshake. Aborted frames pulse frame_err; words dropped
//   because the holding register is still full set the sticky overrun flag.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   usrt_pedge  one-cycle bit strobe
//   size_flag   word length for the next word: 1 = 16 bits, 0 = 8 bits
//   cts         frame enable from the transmitter
//   rxd         serial data, LSB first
//   data        received word (8-bit words zero-extended)
//   data_valid  holding register full
//   data_ready  consumer accepts data when data_valid && data_ready
//   frame_err   one-cycle pulse after a partial word is aborted
//   overrun     sticky: a completed word was dropped
//   busy        a word is partially received
// ---------------------------------------------------------------------------
module section_input #(
  parameter int WORD_MAX = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usrt_pedge,
  input  logic                size_flag,
  input  logic                cts,
  input  logic                rxd,
  output logic [WORD_MAX-1:0] data,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int IDX_W = $clog2(WORD_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t              state_q;
  logic [4:0]          count_q;
  logic                len16_q;   // latched word length for the current word
  logic [WORD_MAX-1:0] shift_q;

  logic                sample;
  logic [4:0]          last_idx;
  logic                word_done;
  logic [WORD_MAX-1:0] word_next;

  assign sample    = cts && usrt_pedge;
  assign last_idx  = len16_q ? 5'd15 : 5'd7;
  assign word_done = (state_q == RECV) && sample && (count_q == last_idx);
  assign busy      = (state_q == RECV);

  // The word as it looks once the current rxd bit is placed at position
  // count; used both to update the shifter and to load the holding register
  // on the completing strobe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    word_next                       = shift_q;
    word_next[count_q[IDX_W-1:0]]   = rxd;
  end

  // Receive sequencer: bit counter, shifter and frame_err pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      len16_q   <= 1'b0;
      shift_q   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample) begin
            // Clearing the shifter here is what zero-extends 8-bit words.
            shift_q    <= '0;
            shift_q[0] <= rxd;
            len16_q    <= size_flag;
            count_q    <= 5'd1;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (!cts) begin
            // cts low wins over a coincident strobe: the bit is not taken.
            state_q   <= IDLE;
            count_q   <= 5'd0;
            frame_err <= 1'b1;
          end else if (usrt_pedge) begin
            shift_q <= word_next;
            if (word_done) begin
              count_q <= 5'd0;
              state_q <= IDLE;
            end else begin
              count_q <= count_q + 5'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One-word holding register. A completion coinciding with a consumer
  // accept replaces the word in place; only a completion into a full,
  // unaccepted register drops the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (word_done) begin
        if (!data_valid || data_ready) begin
          data       <= word_next;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_section_input.sv
// ---------------------------------------------------------------------------
// tb_section_input
//   Self-checking bench for section_input. Expected words are queued as
//   stimulus is sent and compared as the consumer accepts them; each scenario
//   task also checks the control outputs at the relevant edges.
// ---------------------------------------------------------------------------
module tb_section_input;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        usrt_pedge = 1'b0;
  logic        size_flag = 1'b0;
  logic        cts = 1'b0;
  logic        rxd = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [15:0] exp_q[$];

  section_input #(.WORD_MAX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .usrt_pedge (usrt_pedge),
    .size_flag  (size_flag),
    .cts        (cts),
    .rxd        (rxd),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Accept monitor: inputs change just after posedge, so at negedge a
  // valid && ready pair means the word is taken at the next edge.
  always @(negedge clk) begin
    if (!rst && data_valid && data_ready) begin
      logic [15:0] exp_w;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL accept_unexpected: got data=%h, no word expected", data);
      end else begin
        exp_w = exp_q.pop_front();
        if (data !== exp_w)
          $display("FAIL accept_data: got %h, expected %h", data, exp_w);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic strobe(input logic b);
    rxd        = b;
    usrt_pedge = 1'b1;
    @(posedge clk);
    #1;
    usrt_pedge = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int lo, input int hi,
                           input int gap);
    for (int i = lo; i <= hi; i++) begin
      tick(gap);
      strobe(w[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cts = 1'b0;
    usrt_pedge = 1'b0;
    data_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({data, data_valid, frame_err, overrun, busy} !== 20'h0)
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               data, data_valid, frame_err, overrun, busy);
    else
      pass_cnt++;
  endtask

  task automatic test_word8();
    logic [15:0] w = 16'h00A5;
    size_flag = 1'b0;
    data_ready = 1'b1;
    cts = 1'b1;
    exp_q.push_back(w);
    send_bits(w, 0, 6, 16);
    total_cnt++;
    if (busy !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL word8_midword: got busy=%b valid=%b, expected busy=1 valid=0", busy, data_valid);
    else
      pass_cnt++;
    send_bits(w, 7, 7, 16);
    total_cnt++;
    if (data !== 16'h00A5 || data_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL word8_done: got data=%h valid=%b busy=%b, expected 00a5 1 0",
               data, data_valid, busy);
    else
      pass_cnt++;
    wait_drain("word8");
  endtask

  task automatic test_word16_size_change();
    logic [15:0] w = 16'h1234;
    size_flag = 1'b1;
    data_ready = 1'b1;
    cts = 1'b1;
    exp_q.push_back(w);
    send_bits(w, 0, 3, 3);
    size_flag = 1'b0;
    send_bits(w, 4, 7, 3);
    total_cnt++;
    if (busy !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL w16_no_early_done: got busy=%b valid=%b, expected 1 0", busy, data_valid);
    else
      pass_cnt++;
    size_flag = 1'b1;
    send_bits(w, 8, 15, 3);
    total_cnt++;
    if (data !== 16'h1234 || data_valid !== 1'b1 || busy !== 1'b0)
      $display("FAIL w16_done: got data=%h valid=%b busy=%b, expected 1234 1 0",
               data, data_valid, busy);
    else
      pass_cnt++;
    wait_drain("w16");
  endtask

  task automatic test_abort();
    logic [15:0] w = 16'h003C;
    size_flag = 1'b0;
    data_ready = 1'b1;
    cts = 1'b1;
    send_bits(16'h00FF, 0, 2, 3);
    tick(2);
    // cts falls in the same cycle as a strobe: bit dropped, frame aborted.
    cts = 1'b0;
    strobe(1'b1);
    total_cnt++;
    if (frame_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL abort_pulse: got frame_err=%b busy=%b, expected 1 0", frame_err, busy);
    else
      pass_cnt++;
    tick(1);
    total_cnt++;
    if (frame_err !== 1'b0 || data_valid !== 1'b0)
      $display("FAIL abort_pulse_end: got frame_err=%b valid=%b, expected 0 0", frame_err, data_valid);
    else
      pass_cnt++;
    // Strobes with cts low sample nothing.
    strobe(1'b1);
    tick(1);
    total_cnt++;
    if (busy !== 1'b0 || frame_err !== 1'b0)
      $display("FAIL abort_cts_low: got busy=%b frame_err=%b, expected 0 0", busy, frame_err);
    else
      pass_cnt++;
    cts = 1'b1;
    exp_q.push_back(w);
    send_bits(w, 0, 7, 2);
    total_cnt++;
    if (data !== 16'h003C || data_valid !== 1'b1)
      $display("FAIL abort_next_word: got data=%h valid=%b, expected 003c 1", data, data_valid);
    else
      pass_cnt++;
    wait_drain("abort");
  endtask

  task automatic test_back_to_back_accept();
    do_reset();
    size_flag = 1'b0;
    cts = 1'b1;
    exp_q.push_back(16'h0011);
    exp_q.push_back(16'h0022);
    send_bits(16'h0011, 0, 7, 2);
    // Next word starts on the very next strobe, no idle strobe in between.
    send_bits(16'h0022, 0, 6, 0);
    data_ready = 1'b1;
    strobe(1'b0);               // bit 7 of 0x22: completion coincides with accept
    data_ready = 1'b0;
    total_cnt++;
    if (data !== 16'h0022 || data_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL simul_accept: got data=%h valid=%b overrun=%b, expected 0022 1 0",
               data, data_valid, overrun);
    else
      pass_cnt++;
    data_ready = 1'b1;
    wait_drain("simul");
    total_cnt++;
    if (data_valid !== 1'b0 || data !== 16'h0022)
      $display("FAIL simul_after_accept: got valid=%b data=%h, expected 0 0022", data_valid, data);
    else
      pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    size_flag = 1'b0;
    cts = 1'b1;
    exp_q.push_back(16'h0011);  // 0x22 is expected to be dropped
    send_bits(16'h0011, 0, 7, 2);
    send_bits(16'h0022, 0, 7, 2);
    total_cnt++;
    if (data !== 16'h0011 || data_valid !== 1'b1 || overrun !== 1'b1)
      $display("FAIL overrun: got data=%h valid=%b overrun=%b, expected 0011 1 1",
               data, data_valid, overrun);
    else
      pass_cnt++;
    data_ready = 1'b1;
    wait_drain("overrun");
    tick(2);
    total_cnt++;
    if (overrun !== 1'b1 || data_valid !== 1'b0)
      $display("FAIL overrun_sticky: got overrun=%b valid=%b, expected 1 0", overrun, data_valid);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_midword();
    logic [15:0] w = 16'hBEEF;
    size_flag = 1'b1;
    cts = 1'b1;
    data_ready = 1'b1;
    send_bits(16'hFFFF, 0, 4, 2);
    tick(1);
    #2;
    rst = 1'b1;                 // asserted mid-cycle: effect must be immediate
    #1;
    total_cnt++;
    if ({data, data_valid, frame_err, overrun, busy} !== 20'h0)
      $display("FAIL reset_midword: got data=%h v=%b fe=%b ov=%b busy=%b, expected all 0",
               data, data_valid, frame_err, overrun, busy);
    else
      pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    total_cnt++;
    if (frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_no_frame_err: got frame_err=%b busy=%b, expected 0 0", frame_err, busy);
    else
      pass_cnt++;
    exp_q.push_back(w);
    send_bits(w, 0, 15, 2);
    total_cnt++;
    if (data !== 16'hBEEF || data_valid !== 1'b1)
      $display("FAIL reset_next_word: got data=%h valid=%b, expected beef 1", data, data_valid);
    else
      pass_cnt++;
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_word8();
    test_word16_size_change();
    test_abort();
    test_back_to_back_accept();
    test_overrun();
    test_reset_midword();
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
